// File: rtl/pc_sp_update_ctrl_pkg.sv
// Shared definitions for the PC/SP update controller: sequencer states,
// adder operand selects and the word-offset helper.
package pc_sp_update_ctrl_pkg;

    localparam int          WORD_W     = 16;
    localparam logic [15:0] STACK_STEP = 16'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CALL_MEM = 3'd1,
        CALL_PC  = 3'd2,
        RET_MEM  = 3'd3,
        RET_SP   = 3'd4
    } state_e;

    typedef enum logic {
        OPA_PC = 1'b0,
        OPA_SP = 1'b1
    } opa_e;

    typedef enum logic [1:0] {
        OPB_PLUS2  = 2'd0,
        OPB_MINUS2 = 2'd1,
        OPB_IMM    = 2'd2,
        OPB_OFFQ   = 2'd3
    } opb_e;

    // Instruction offsets count 16-bit words, so the byte offset is imm*2.
    function automatic logic signed [WORD_W-1:0] word_offset(input logic signed [9:0] imm);
        return {{5{imm[9]}}, imm, 1'b0};
    endfunction

endpackage

// File: rtl/pc_sp_update_ctrl_adder.sv
// The single shared 16-bit adder: picks PC or SP as base and one of
// +2 / -2 / sign-extended immediate / latched call offset as addend.
module addr_offset_adder
    import pc_sp_update_ctrl_pkg::*;
(
    input  logic        opa_sel,
    input  logic [1:0]  opb_sel,
    input  logic [15:0] pc,
    input  logic [15:0] sp,
    input  logic [9:0]  imm,
    input  logic [15:0] off_q,
    output logic [15:0] imm_off,
    output logic [15:0] sum
);

    logic signed [WORD_W-1:0] op_a;
    logic signed [WORD_W-1:0] op_b;

    assign imm_off = word_offset(imm);

    always_comb begin
        op_a = (opa_e'(opa_sel) == OPA_SP) ? sp : pc;
        op_b = '0;
        case (opb_e'(opb_sel))
            OPB_PLUS2:  op_b = STACK_STEP;
            OPB_MINUS2: op_b = -STACK_STEP;
            OPB_IMM:    op_b = imm_off;
            OPB_OFFQ:   op_b = off_q;
            default:    op_b = '0;
        endcase
        sum = op_a + op_b;
    end

endmodule

// File: rtl/pc_sp_update_ctrl.sv
// Sole writer of PC and SP: arbitrates step / imm / CALL / RET requests and
// sequences the multi-cycle CALL and RET stack accesses through one adder.
module pc_sp_update_ctrl
    import pc_sp_update_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] RESET_SP = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_valid,
    output logic        step_ready,
    input  logic        imm_valid,
    output logic        imm_ready,
    input  logic        imm_sel,
    input  logic [9:0]  imm_val,
    input  logic        call_valid,
    output logic        call_ready,
    input  logic [9:0]  call_imm,
    input  logic        ret_valid,
    output logic        ret_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] pc,
    output logic [15:0] sp,
    output logic        busy
);

    state_e      state, state_nxt;
    opa_e        opa_sel;
    opb_e        opb_sel;
    logic [9:0]  imm_src;
    logic [15:0] imm_off;
    logic [15:0] sum;
    logic [15:0] off_q;
    logic        call_go, ret_go, imm_go, step_go;

    addr_offset_adder u_adder (
        .opa_sel (opa_sel),
        .opb_sel (opb_sel),
        .pc      (pc),
        .sp      (sp),
        .imm     (imm_src),
        .off_q   (off_q),
        .imm_off (imm_off),
        .sum     (sum)
    );

    assign call_go = call_valid && call_ready;
    assign ret_go  = ret_valid  && ret_ready;
    assign imm_go  = imm_valid  && imm_ready;
    assign step_go = step_valid && step_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (call_go)     state_nxt = CALL_MEM;
                else if (ret_go) state_nxt = RET_MEM;
            end
            CALL_MEM: if (mem_ack) state_nxt = CALL_PC;
            CALL_PC:  state_nxt = IDLE;
            RET_MEM:  if (mem_ack) state_nxt = RET_SP;
            RET_SP:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Readies are masked by rst_n so nothing is accepted while reset is held.
    always_comb begin
        call_ready = 1'b0;
        ret_ready  = 1'b0;
        imm_ready  = 1'b0;
        step_ready = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = sp;
        opa_sel    = OPA_PC;
        opb_sel    = OPB_PLUS2;
        imm_src    = imm_val;
        case (state)
            IDLE: begin
                call_ready = rst_n;
                ret_ready  = rst_n && !call_valid;
                imm_ready  = rst_n && !call_valid && !ret_valid;
                step_ready = rst_n && !call_valid && !ret_valid && !imm_valid;
                if (call_valid) begin
                    opa_sel = OPA_SP;
                    opb_sel = OPB_MINUS2;
                    imm_src = call_imm;
                end else if (imm_valid) begin
                    opa_sel = imm_sel ? OPA_PC : OPA_SP;
                    opb_sel = OPB_IMM;
                end
            end
            CALL_MEM: mem_we = 1'b1;
            CALL_PC:  opb_sel = OPB_OFFQ;
            RET_MEM:  mem_re = 1'b1;
            RET_SP:   opa_sel = OPA_SP;
            default: ;
        endcase
    end

    assign mem_wdata = sum;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            sp <= RESET_SP;
        end else begin
            case (state)
                IDLE: begin
                    if (call_go)                sp <= sum;
                    else if (imm_go && imm_sel) pc <= sum;
                    else if (imm_go)            sp <= sum;
                    else if (step_go)           pc <= sum;
                end
                CALL_PC: pc <= sum;
                RET_MEM: if (mem_ack) pc <= mem_rdata;
                RET_SP:  sp <= sum;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (call_go) off_q <= imm_off;
    end

endmodule

// File: tb/tb_pc_sp_update_ctrl.sv
// Directed bench for pc_sp_update_ctrl: step, immediate, priority, CALL,
// RET, wrap-around and mid-sequence reset scenarios.
module tb_pc_sp_update_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        step_valid, step_ready;
    logic        imm_valid, imm_ready, imm_sel;
    logic [9:0]  imm_val;
    logic        call_valid, call_ready;
    logic [9:0]  call_imm;
    logic        ret_valid, ret_ready;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, pc, sp;
    logic        mem_we, mem_re, mem_ack, busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    pc_sp_update_ctrl #(.RESET_PC(16'h0000), .RESET_SP(16'hFFFE)) dut (
        .clk(clk), .rst_n(rst_n),
        .step_valid(step_valid), .step_ready(step_ready),
        .imm_valid(imm_valid), .imm_ready(imm_ready), .imm_sel(imm_sel), .imm_val(imm_val),
        .call_valid(call_valid), .call_ready(call_ready), .call_imm(call_imm),
        .ret_valid(ret_valid), .ret_ready(ret_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pc(pc), .sp(sp), .busy(busy)
    );

    always #5 clk = ~clk;

    // Each task starts and ends 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step_valid = 0; imm_valid = 0; imm_sel = 0; imm_val = '0;
        call_valid = 0; call_imm = '0; ret_valid = 0;
        mem_ack = 0; mem_rdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_reg_imm(input logic sel, input logic [9:0] v);
        imm_valid = 1; imm_sel = sel; imm_val = v;
        tick();
        imm_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step_valid = 1; imm_valid = 1; imm_sel = 1; imm_val = '0;
        call_valid = 1; call_imm = '0; ret_valid = 1;
        mem_ack = 0; mem_rdata = '0;
        tick();
        @(negedge clk);
        total_cnt++;
        if ({pc, sp} !== {16'h0000, 16'hFFFE})
            $display("FAIL reset_regs: pc=%h sp=%h, expected pc=0000 sp=fffe", pc, sp);
        else pass_cnt++;
        total_cnt++;
        if ({busy, mem_we, mem_re, call_ready, ret_ready, imm_ready, step_ready} !== 7'b0)
            $display("FAIL reset_ctrl: busy/we/re/readies=%b, expected 0000000",
                     {busy, mem_we, mem_re, call_ready, ret_ready, imm_ready, step_ready});
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_step();
        logic [15:0] exp_pc;
        exp_pc = 16'h0000;
        step_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if (step_ready !== 1'b1) $display("FAIL step_ready[%0d]: got %b, expected 1", i, step_ready);
            else pass_cnt++;
            tick();
            exp_pc = exp_pc + 16'h0002;
            total_cnt++;
            if (pc !== exp_pc) $display("FAIL step_pc[%0d]: got %h, expected %h", i, pc, exp_pc);
            else pass_cnt++;
        end
        step_valid = 0;
    endtask

    task automatic test_imm();
        set_reg_imm(1'b1, 10'h005);  // pc 0006 + 10 = 0010
        total_cnt++;
        if (pc !== 16'h0010) $display("FAIL imm_pc_pos: got %h, expected 0010", pc);
        else pass_cnt++;
        set_reg_imm(1'b1, 10'h3FF);
        total_cnt++;
        if (pc !== 16'h000E) $display("FAIL imm_pc_neg: got %h, expected 000e", pc);
        else pass_cnt++;
        set_reg_imm(1'b0, 10'h200);
        total_cnt++;
        if ({pc, sp} !== {16'h000E, 16'hFBFE})
            $display("FAIL imm_sp_min: pc=%h sp=%h, expected pc=000e sp=fbfe", pc, sp);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        do_reset();
        imm_valid = 1; imm_sel = 1; imm_val = 10'h004; step_valid = 1;
        @(negedge clk);
        total_cnt++;
        if ({imm_ready, step_ready} !== 2'b10)
            $display("FAIL prio_ready: imm/step=%b, expected 10", {imm_ready, step_ready});
        else pass_cnt++;
        tick();
        imm_valid = 0;
        total_cnt++;
        if (pc !== 16'h0008) $display("FAIL prio_imm_first: got %h, expected 0008", pc);
        else pass_cnt++;
        tick();
        step_valid = 0;
        total_cnt++;
        if (pc !== 16'h000A) $display("FAIL prio_step_next: got %h, expected 000a", pc);
        else pass_cnt++;
    endtask

    task automatic test_call();
        do_reset();
        set_reg_imm(1'b1, 10'h080);  // pc = 0100
        call_valid = 1; call_imm = 10'h010; step_valid = 1;
        @(negedge clk);
        total_cnt++;
        if ({call_ready, step_ready} !== 2'b10)
            $display("FAIL call_grant: call/step=%b, expected 10", {call_ready, step_ready});
        else pass_cnt++;
        tick();
        call_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({mem_we, mem_re, busy, step_ready, mem_addr, mem_wdata, sp} !==
                {4'b1010, 16'hFFFC, 16'h0102, 16'hFFFC})
                $display("FAIL call_mem[%0d]: we=%b re=%b busy=%b sready=%b addr=%h wdata=%h sp=%h, expected 1 0 1 0 fffc 0102 fffc",
                         i, mem_we, mem_re, busy, step_ready, mem_addr, mem_wdata, sp);
            else pass_cnt++;
            if (i == 2) mem_ack = 1;
            tick();
        end
        mem_ack = 0;
        total_cnt++;
        if ({mem_we, busy, step_ready, pc} !== {3'b010, 16'h0100})
            $display("FAIL call_pc_state: we=%b busy=%b sready=%b pc=%h, expected 0 1 0 0100",
                     mem_we, busy, step_ready, pc);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({busy, pc, sp} !== {1'b0, 16'h0120, 16'hFFFC})
            $display("FAIL call_done: busy=%b pc=%h sp=%h, expected 0 0120 fffc", busy, pc, sp);
        else pass_cnt++;
        tick();
        step_valid = 0;
        total_cnt++;
        if (pc !== 16'h0122) $display("FAIL call_stalled_step: pc=%h, expected 0122", pc);
        else pass_cnt++;
    endtask

    task automatic test_ret();
        ret_valid = 1;
        @(negedge clk);
        total_cnt++;
        if (ret_ready !== 1'b1) $display("FAIL ret_ready: got %b, expected 1", ret_ready);
        else pass_cnt++;
        tick();
        ret_valid = 0;
        @(negedge clk);
        total_cnt++;
        if ({mem_re, mem_we, busy, mem_addr} !== {3'b101, 16'hFFFC})
            $display("FAIL ret_mem: re=%b we=%b busy=%b addr=%h, expected 1 0 1 fffc",
                     mem_re, mem_we, busy, mem_addr);
        else pass_cnt++;
        mem_ack = 1; mem_rdata = 16'h0102;
        tick();
        mem_ack = 0; mem_rdata = 16'hDEAD;
        total_cnt++;
        if ({mem_re, busy, pc, sp} !== {2'b01, 16'h0102, 16'hFFFC})
            $display("FAIL ret_sp_state: re=%b busy=%b pc=%h sp=%h, expected 0 1 0102 fffc",
                     mem_re, busy, pc, sp);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({busy, pc, sp} !== {1'b0, 16'h0102, 16'hFFFE})
            $display("FAIL ret_done: busy=%b pc=%h sp=%h, expected 0 0102 fffe", busy, pc, sp);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        set_reg_imm(1'b1, 10'h3FF);  // pc = fffe
        step_valid = 1;
        tick();
        step_valid = 0;
        total_cnt++;
        if (pc !== 16'h0000) $display("FAIL wrap_pc_step: got %h, expected 0000", pc);
        else pass_cnt++;
        mem_ack = 1;  // ack while idle must have no effect
        tick();
        mem_ack = 0;
        total_cnt++;
        if ({busy, pc, sp} !== {1'b0, 16'h0000, 16'hFFFE})
            $display("FAIL idle_ack_ignored: busy=%b pc=%h sp=%h, expected 0 0000 fffe", busy, pc, sp);
        else pass_cnt++;
        set_reg_imm(1'b0, 10'h001);  // sp = 0000
        call_valid = 1; call_imm = 10'h000;
        tick();
        call_valid = 0;
        @(negedge clk);
        total_cnt++;
        if ({mem_we, sp, mem_addr, mem_wdata} !== {1'b1, 16'hFFFE, 16'hFFFE, 16'h0002})
            $display("FAIL wrap_sp_call: we=%b sp=%h addr=%h wdata=%h, expected 1 fffe fffe 0002",
                     mem_we, sp, mem_addr, mem_wdata);
        else pass_cnt++;
        mem_ack = 1;
        tick();
        mem_ack = 0;
        tick();
        total_cnt++;
        if ({busy, pc, sp} !== {1'b0, 16'h0000, 16'hFFFE})
            $display("FAIL wrap_call_done: busy=%b pc=%h sp=%h, expected 0 0000 fffe", busy, pc, sp);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_reg_imm(1'b1, 10'h040);  // pc = 0080
        call_valid = 1; call_imm = 10'h020;
        tick();
        call_valid = 0;
        @(negedge clk);
        total_cnt++;
        if ({mem_we, sp} !== {1'b1, 16'hFFFC})
            $display("FAIL mid_pre: we=%b sp=%h, expected 1 fffc", mem_we, sp);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({mem_we, busy, pc, sp} !== {2'b00, 16'h0000, 16'hFFFE})
            $display("FAIL mid_async: we=%b busy=%b pc=%h sp=%h, expected 0 0 0000 fffe",
                     mem_we, busy, pc, sp);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        mem_ack = 1;
        tick();
        mem_ack = 0;
        tick();
        total_cnt++;
        if ({busy, mem_we, pc, sp} !== {2'b00, 16'h0000, 16'hFFFE})
            $display("FAIL mid_late_ack: busy=%b we=%b pc=%h sp=%h, expected 0 0 0000 fffe",
                     busy, mem_we, pc, sp);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_step();
        test_imm();
        test_priority();
        test_call();
        test_ret();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pc_sp_update_ctrl.md
Name: pc_sp_update_ctrl

Overview:
Owns the architectural PC and SP registers and sequences every update to them through one shared 16-bit adder. Sources of updates are the fetch step (PC+2), the immediate-relative CHGPCI/CHGSPI path, and the multi-cycle CALL and RET sequences, which also drive the stack memory port. It sits between decode, fetch and data memory and is the sole writer of PC and SP.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
RESET_SP, 16'hFFFE, SP value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
step_valid  in  1  fetch requests PC += 2
step_ready  out  1  step accepted this cycle
imm_valid  in  1  CHGPCI/CHGSPI request
imm_ready  out  1  imm request accepted this cycle
imm_sel  in  1  1 = PC target (CHGPCI), 0 = SP target (CHGSPI)
imm_val  in  10  signed word offset from instruction[9:0]
call_valid  in  1  CALL request
call_ready  out  1  CALL accepted this cycle
call_imm  in  10  signed word offset of call target
ret_valid  in  1  RET request
ret_ready  out  1  RET accepted this cycle
mem_addr  out  16  stack memory address
mem_wdata  out  16  return address to push
mem_we  out  1  stack write strobe
mem_re  out  1  stack read strobe
mem_ack  in  1  memory completes the current strobe
mem_rdata  in  16  popped return address, valid with mem_ack
pc  out  16  current PC (registered)
sp  out  16  current SP (registered)
busy  out  1  high in any state other than IDLE

Behaviour:
- Offset: off = 16-bit sign extension of {imm, 1'b0}, i.e. imm sign-extended and shifted left by 1, range -1024..+1022. All sums are mod 2^16 and wrap silently.
- Reset (async, rst_n=0): pc=RESET_PC, sp=RESET_SP, state=IDLE; mem_we, mem_re, busy and all *_ready are 0 immediately.
- Handshake: a request transfers on a cycle with valid && ready. Ready is combinational from state and higher-priority valids. Requesters hold valid and payload until accepted.
- IDLE arbitration, fixed priority call > ret > imm > step. Exactly one request is granted per cycle, and only in IDLE.
- imm grant: the selected register gets reg + off at that clock edge; 1-cycle latency; state stays IDLE.
- step grant: pc += 2 at that edge; state stays IDLE.
- call grant: latch off(call_imm) into off_q; sp -= 2; go to CALL_MEM.
- CALL_MEM: mem_we=1, mem_addr=sp (already decremented), mem_wdata=pc+2 from the shared adder. Hold until mem_ack, then go to CALL_PC.
- CALL_PC: pc += off_q; go to IDLE. Minimum CALL length is 3 cycles.
- ret grant: go to RET_MEM; no register change.
- RET_MEM: mem_re=1, mem_addr=sp. Hold until mem_ack, then pc <= mem_rdata and go to RET_SP.
- RET_SP: sp += 2; go to IDLE. Minimum RET length is 3 cycles.
- The adder is used at most once per cycle. In IDLE its input is chosen by the grant; in sequence states it is fixed by the state.
- Boundaries:
  - mem_ack in IDLE, CALL_PC or RET_SP is ignored.
  - Requests arriving while busy are not accepted and not lost, since their valid is still held.
  - sp=0x0000 on CALL wraps to 0xFFFE.
  - pc=0xFFFE with step wraps to 0x0000.
- Reset mid-sequence aborts immediately to IDLE. No partial update is undone, so SP may already have been decremented.

Decomposition:
- Shared package: state encoding (IDLE, CALL_MEM, CALL_PC, RET_MEM, RET_SP), the 16-bit word width constant, and the stack step constant 2.
- One sub-module: addr_offset_adder, a purely combinational block with operand-select and sign-extend/shift of the 10-bit immediate. It is the single shared adder instance.

Test Plan:
- Reset then step_valid held for 3 cycles: pc 0x0000→0x0002→0x0004→0x0006; step_ready=1 each cycle.
- imm_sel=1, imm_val=10'h3FF (-1), pc=0x0010: next cycle pc=0x000E. Then imm_sel=0, imm_val=10'h200 (-512), sp=0xFFFE: sp=0xFBFE.
- imm_valid and step_valid asserted together: imm_ready=1, step_ready=0. The imm update applies first and the step applies the following cycle.
- CALL with pc=0x0100, sp=0xFFFE, call_imm=10'h010, mem_ack delayed 2 cycles:
  - mem_we held 3 cycles with addr=0xFFFC, wdata=0x0102.
  - Afterwards pc=0x0120, sp=0xFFFC.
  - busy=1 throughout, and a concurrent step is stalled.
- RET with sp=0xFFFC, mem_rdata=0x0102 on ack: mem_re with addr=0xFFFC; then pc=0x0102, sp=0xFFFE, back in IDLE after 3 cycles.
- rst_n pulsed low during CALL_MEM: mem_we drops asynchronously, pc=RESET_PC, sp=RESET_SP, state=IDLE, and a later ack is ignored.
